// File: rtl/cpu_control_unit.sv
// ----------------------------------------------------------------------------
// cpu_control_unit
//
// Multi-cycle sequencer for the accumulator CPU (PC, MAR, MBR, IR, ACC).
// It fetches an instruction, decodes the opcode held in IR, runs the operand
// or store memory phases, and drives the register-file load strobes, the
// datapath mux selects and a request/ready memory handshake. It also flags
// memory timeouts (FAULT) and undefined opcodes (illegal_op).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   run        permit starting a new instruction (sampled at boundaries)
//   ir_out     current IR contents; opcode is ir_out[15 -: OPCODE_W]
//   acc_zero   ACC == 0 from the datapath (used by JZ)
//   mem_ready  memory completes the current request this cycle
//   mem_req    memory request, held until mem_ready
//   mem_we     1 = write MBR to mem[MAR], 0 = read; valid with mem_req
//   pc_write / mar_write / mbr_write / ir_write / acc_write
//              register load strobes, sampled on the next rising edge
//   pc_sel     0: PC+1, 1: ir_out[11:0]
//   mar_sel    0: PC,   1: ir_out[11:0]
//   mbr_sel    0: memory read data, 1: ACC
//   acc_sel    00: MBR, 01: ACC+MBR, 10: ACC-MBR
//   halted     high in HALTED
//   fault      high in FAULT
//   illegal_op one-cycle pulse in DECODE on an undefined opcode
//   state_out  current state encoding, for debug
// ----------------------------------------------------------------------------
module cpu_control_unit #(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir_out,
    input  logic        acc_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_write,
    output logic        mar_write,
    output logic        mbr_write,
    output logic        ir_write,
    output logic        acc_write,
    output logic        pc_sel,
    output logic        mar_sel,
    output logic        mbr_sel,
    output logic [1:0]  acc_sel,
    output logic        halted,
    output logic        fault,
    output logic        illegal_op,
    output logic [3:0]  state_out
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'h0,
        S_FETCH_ADDR = 4'h1,
        S_FETCH_MEM  = 4'h2,
        S_FETCH_IR   = 4'h3,
        S_DECODE     = 4'h4,
        S_OPND_ADDR  = 4'h5,
        S_OPND_MEM   = 4'h6,
        S_EXEC       = 4'h7,
        S_ST_ADDR    = 4'h8,
        S_ST_MEM     = 4'h9,
        S_HALTED     = 4'hA,
        S_FAULT      = 4'hB
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JZ    = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(7);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [OPCODE_W-1:0] opcode;
    logic               in_mem_state;
    state_t             boundary_state;

    assign opcode         = ir_out[15 -: OPCODE_W];
    assign in_mem_state   = (state == S_FETCH_MEM) || (state == S_OPND_MEM) ||
                            (state == S_ST_MEM);
    // Instruction boundary: run is only looked at here.
    assign boundary_state = run ? S_FETCH_ADDR : S_IDLE;
    assign state_out      = state;

    // Next state and combinational outputs
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_write   = 1'b0;
        mar_write  = 1'b0;
        mbr_write  = 1'b0;
        ir_write   = 1'b0;
        acc_write  = 1'b0;
        pc_sel     = 1'b0;
        mar_sel    = 1'b0;
        mbr_sel    = 1'b0;
        acc_sel    = 2'b00;
        halted     = 1'b0;
        fault      = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) next_state = S_FETCH_ADDR;
            end
            S_FETCH_ADDR: begin
                mar_write  = 1'b1;
                next_state = S_FETCH_MEM;
            end
            S_FETCH_MEM, S_OPND_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    mbr_write  = 1'b1;
                    next_state = (state == S_FETCH_MEM) ? S_FETCH_IR : S_EXEC;
                end else if (wait_cnt == CNT_LAST) begin
                    next_state = S_FAULT;
                end
            end
            S_FETCH_IR: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:                 next_state = boundary_state;
                    OP_LOAD, OP_ADD, OP_SUB: next_state = S_OPND_ADDR;
                    OP_STORE:               next_state = S_ST_ADDR;
                    OP_JMP: begin
                        pc_write   = 1'b1;
                        pc_sel     = 1'b1;
                        next_state = boundary_state;
                    end
                    OP_JZ: begin
                        pc_write   = acc_zero;
                        pc_sel     = 1'b1;
                        next_state = boundary_state;
                    end
                    OP_HALT:                next_state = S_HALTED;
                    default: begin
                        // Undefined opcodes retire as a NOP.
                        illegal_op = 1'b1;
                        next_state = boundary_state;
                    end
                endcase
            end
            S_OPND_ADDR: begin
                mar_write  = 1'b1;
                mar_sel    = 1'b1;
                next_state = S_OPND_MEM;
            end
            S_EXEC: begin
                acc_write = 1'b1;
                case (opcode)
                    OP_ADD:  acc_sel = 2'b01;
                    OP_SUB:  acc_sel = 2'b10;
                    default: acc_sel = 2'b00;
                endcase
                next_state = boundary_state;
            end
            S_ST_ADDR: begin
                mar_write  = 1'b1;
                mar_sel    = 1'b1;
                mbr_write  = 1'b1;
                mbr_sel    = 1'b1;
                next_state = S_ST_MEM;
            end
            S_ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready)                 next_state = boundary_state;
                else if (wait_cnt == CNT_LAST) next_state = S_FAULT;
            end
            S_HALTED: halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default:  next_state = S_IDLE;
        endcase
    end

    // State register and memory wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            // Held at zero outside memory states, so every memory state
            // is entered with a cleared counter.
            if (in_mem_state && !mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
            else                            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] ir_out;
    logic        acc_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, pc_write, mar_write, mbr_write, ir_write;
    logic        acc_write, pc_sel, mar_sel, mbr_sel, halted, fault, illegal_op;
    logic [1:0]  acc_sel;
    logic [3:0]  state_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Output flag bit positions inside the packed observation vector
    localparam logic [14:0] ILL = 15'h0001;
    localparam logic [14:0] FLT = 15'h0002;
    localparam logic [14:0] HLT = 15'h0004;
    localparam logic [14:0] AS0 = 15'h0008;
    localparam logic [14:0] AS1 = 15'h0010;
    localparam logic [14:0] MBS = 15'h0020;
    localparam logic [14:0] MAS = 15'h0040;
    localparam logic [14:0] PCS = 15'h0080;
    localparam logic [14:0] ACW = 15'h0100;
    localparam logic [14:0] IRW = 15'h0200;
    localparam logic [14:0] MBW = 15'h0400;
    localparam logic [14:0] MAW = 15'h0800;
    localparam logic [14:0] PCW = 15'h1000;
    localparam logic [14:0] MWE = 15'h2000;
    localparam logic [14:0] MRQ = 15'h4000;

    logic [18:0] outs;
    assign outs = {state_out, mem_req, mem_we, pc_write, mar_write, mbr_write,
                   ir_write, acc_write, pc_sel, mar_sel, mbr_sel, acc_sel,
                   halted, fault, illegal_op};

    cpu_control_unit #(.OPCODE_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run), .ir_out(ir_out),
        .acc_zero(acc_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .pc_write(pc_write), .mar_write(mar_write),
        .mbr_write(mbr_write), .ir_write(ir_write), .acc_write(acc_write),
        .pc_sel(pc_sel), .mar_sel(mar_sel), .mbr_sel(mbr_sel),
        .acc_sel(acc_sel), .halted(halted), .fault(fault),
        .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] e(input logic [3:0] st, input logic [14:0] f);
        return {st, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply mem_ready for the new cycle, let outputs settle, check.
    task automatic cyc(input logic rdy, input logic [18:0] exp, input string tag);
        @(posedge clk);
        #1 mem_ready = rdy;
        #1 chk(tag, {13'd0, outs}, {13'd0, exp});
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ir_out = 16'h0000; acc_zero = 1'b0; mem_ready = 1'b0;
        #1 chk("reset_outs", {13'd0, outs}, 32'd0);

        // LOAD 5, zero-wait memory
        run = 1'b1; mem_ready = 1'b1; ir_out = 16'h1005;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("idle_after_reset", {13'd0, outs}, 32'd0);
        cyc(1, e(1, MAW),       "ld_fetch_addr");
        cyc(1, e(2, MRQ | MBW), "ld_fetch_mem");
        cyc(1, e(3, IRW | PCW), "ld_fetch_ir");
        cyc(1, e(4, 15'd0),     "ld_decode");
        cyc(1, e(5, MAW | MAS), "ld_opnd_addr");
        cyc(1, e(6, MRQ | MBW), "ld_opnd_mem");
        cyc(1, e(7, ACW),       "ld_exec");

        // STORE 0x010, memory ready only on the 4th ST_MEM cycle
        ir_out = 16'h2010;
        cyc(1, e(1, MAW),                   "st_fetch_addr");
        cyc(1, e(2, MRQ | MBW),             "st_fetch_mem");
        cyc(1, e(3, IRW | PCW),             "st_fetch_ir");
        cyc(1, e(4, 15'd0),                 "st_decode");
        cyc(0, e(8, MAW | MAS | MBW | MBS), "st_addr");
        cyc(0, e(9, MRQ | MWE),             "st_mem_w1");
        cyc(0, e(9, MRQ | MWE),             "st_mem_w2");
        cyc(0, e(9, MRQ | MWE),             "st_mem_w3");
        cyc(1, e(9, MRQ | MWE),             "st_mem_ready");
        cyc(1, e(1, MAW),                   "st_next_fetch");

        // JZ taken, then not taken
        ir_out = 16'h6123; acc_zero = 1'b1;
        cyc(1, e(2, MRQ | MBW), "jz1_fetch_mem");
        cyc(1, e(3, IRW | PCW), "jz1_fetch_ir");
        cyc(1, e(4, PCW | PCS), "jz1_decode_taken");
        cyc(1, e(1, MAW),       "jz1_next");
        acc_zero = 1'b0;
        cyc(1, e(2, MRQ | MBW), "jz0_fetch_mem");
        cyc(1, e(3, IRW | PCW), "jz0_fetch_ir");
        cyc(1, e(4, PCS),       "jz0_decode_not_taken");
        cyc(1, e(1, MAW),       "jz0_next");

        // Illegal opcode, then HALT
        ir_out = 16'hF000;
        cyc(1, e(2, MRQ | MBW), "ill_fetch_mem");
        cyc(1, e(3, IRW | PCW), "ill_fetch_ir");
        cyc(1, e(4, ILL),       "ill_decode_pulse");
        cyc(1, e(1, MAW),       "ill_pulse_ends");
        ir_out = 16'h7000;
        cyc(1, e(2, MRQ | MBW), "hlt_fetch_mem");
        cyc(1, e(3, IRW | PCW), "hlt_fetch_ir");
        cyc(1, e(4, 15'd0),     "hlt_decode");
        cyc(1, e(10, HLT),      "halted");
        run = 1'b0;
        cyc(1, e(10, HLT),      "halted_run0");
        run = 1'b1;
        cyc(1, e(10, HLT),      "halted_run1");

        // Fetch timeout: mem_req high exactly 4 cycles, then FAULT until reset
        @(posedge clk);
        #1 reset = 1'b1; mem_ready = 1'b0;
        #1 chk("reset_from_halt", {13'd0, outs}, 32'd0);
        reset = 1'b0;
        cyc(0, e(1, MAW),  "to_fetch_addr");
        cyc(0, e(2, MRQ),  "to_wait1");
        cyc(0, e(2, MRQ),  "to_wait2");
        cyc(0, e(2, MRQ),  "to_wait3");
        cyc(0, e(2, MRQ),  "to_wait4");
        cyc(0, e(11, FLT), "to_fault");
        cyc(1, e(11, FLT), "to_fault_hold1");
        run = 1'b0;
        cyc(1, e(11, FLT), "to_fault_hold2");
        #2 reset = 1'b1;
        #1 chk("reset_from_fault", {13'd0, outs}, 32'd0);

        // ADD with run dropped during OPND_MEM
        run = 1'b1; ir_out = 16'h3007;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("add_idle", {13'd0, outs}, 32'd0);
        cyc(1, e(1, MAW),       "add_fetch_addr");
        cyc(1, e(2, MRQ | MBW), "add_fetch_mem");
        cyc(1, e(3, IRW | PCW), "add_fetch_ir");
        cyc(1, e(4, 15'd0),     "add_decode");
        cyc(1, e(5, MAW | MAS), "add_opnd_addr");
        run = 1'b0;
        cyc(0, e(6, MRQ),       "add_opnd_wait");
        cyc(1, e(6, MRQ | MBW), "add_opnd_ready");
        cyc(1, e(7, ACW | AS0), "add_exec");
        cyc(1, e(0, 15'd0),     "add_idle_run0_a");
        cyc(1, e(0, 15'd0),     "add_idle_run0_b");
        run = 1'b1;
        cyc(1, e(1, MAW),       "resume_fetch_addr");
        cyc(0, e(2, MRQ),       "resume_fetch_wait");

        // Async reset mid-handshake, well away from a clock edge
        #2 reset = 1'b1;
        #1 chk("async_reset_no_edge", {13'd0, outs}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
